// File: rtl/spi_slave_if.sv
// SPI slave (modes 0-3, MSB first, 8-bit) oversampled in clk; pin edge to action 3 cycles, rx_valid 4 cycles after last sample edge.
// TX side is a one-entry valid/ready holding register; an empty register at a byte start sends 0x00 and flags tx_underrun.
module spi_slave_if (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [1:0] mode,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {WAIT_HI, IDLE, ARM, SHIFT} state_t;

    state_t     state, state_nxt;
    logic       sck_s1, sck_s2, sck_s3, cs_s1, cs_s2, mosi_s1, mosi_s2;
    logic [1:0] sync_ok;
    logic [1:0] mode_q;
    logic [7:0] tx_sh, hold_dat;
    logic [6:0] rx_sh;
    logic [2:0] cnt;
    logic       hold_full, done_q, pend_ur;
    logic       sck_edge, lead, trail, in_shift, sample_edge, shift_edge, boundary, load_tx, write_ok;

    assign sck_edge    = sck_s2 ^ sck_s3;
    assign lead        = sck_edge & (sck_s3 == mode_q[1]);
    assign trail       = sck_edge & (sck_s2 == mode_q[1]);
    assign in_shift    = (state == SHIFT) & ~cs_s2;
    assign sample_edge = in_shift & (mode_q[0] ? trail : lead);
    // No shift on the first shift-type edge of a byte: the freshly loaded MSB must stay on MISO.
    assign shift_edge  = in_shift & (mode_q[0] ? lead : trail) & (cnt != 3'd0);
    assign boundary    = sample_edge & (cnt == 3'd7);
    assign load_tx     = (state == ARM) | boundary;
    assign write_ok    = tx_valid & ~hold_full;

    assign tx_ready    = ~hold_full;
    assign busy        = (state == ARM) | (state == SHIFT);
    assign spi_miso_oe = ~cs_s2 & (state != WAIT_HI);
    assign spi_miso    = spi_miso_oe & tx_sh[7];

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_HI: if (sync_ok[1] && cs_s2) state_nxt = IDLE;
            IDLE:    if (!cs_s2) state_nxt = ARM;
            ARM:     state_nxt = SHIFT;
            SHIFT:   if (cs_s2) state_nxt = IDLE;
            default: state_nxt = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_HI;
            sck_s1      <= 1'b0;
            sck_s2      <= 1'b0;
            sck_s3      <= 1'b0;
            cs_s1       <= 1'b1;
            cs_s2       <= 1'b1;
            mosi_s1     <= 1'b0;
            mosi_s2     <= 1'b0;
            sync_ok     <= 2'b00;
            mode_q      <= 2'b00;
            tx_sh       <= 8'h00;
            rx_sh       <= 7'h00;
            hold_dat    <= 8'h00;
            hold_full   <= 1'b0;
            cnt         <= 3'd0;
            done_q      <= 1'b0;
            pend_ur     <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
            // The cs_n synchroniser holds its reset value for two cycles; WAIT_HI must not trust it until then.
            sync_ok <= {sync_ok[0], 1'b1};
            state   <= state_nxt;

            done_q    <= boundary;
            rx_valid  <= done_q;
            frame_err <= (state == SHIFT) & cs_s2 & (cnt != 3'd0);
            // An empty register at a byte boundary is only an underrun once the next byte really starts.
            tx_underrun <= ((state == ARM) & ~hold_full) |
                           (sample_edge & (cnt == 3'd0) & pend_ur);
            if (state == ARM)
                pend_ur <= 1'b0;
            else if (sample_edge)
                pend_ur <= boundary & ~hold_full;

            if (state == ARM) begin
                mode_q <= mode;
                cnt    <= 3'd0;
            end

            if (load_tx)
                tx_sh <= hold_full ? hold_dat : 8'h00;
            else if (shift_edge)
                tx_sh <= {tx_sh[6:0], 1'b0};

            if (sample_edge) begin
                rx_sh <= {rx_sh[5:0], mosi_s2};
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7)
                    rx_data <= {rx_sh, mosi_s2};
            end

            if (write_ok) begin
                hold_full <= 1'b1;
                hold_dat  <= tx_data;
            end else if (load_tx && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a bench-side SPI master plus a scoreboard monitor checking every cycle.
module tb_spi_slave_if;

    localparam int H = 8;

    logic       clk, rst, sck, cs_n, mosi, miso, miso_oe;
    logic [1:0] mode;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, tx_underrun, frame_err, busy;

    spi_slave_if dut (
        .clk(clk), .rst(rst), .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(miso_oe), .mode(mode),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_samp_cyc = 0;
    int n_rxv = 0, n_ur = 0, n_fe = 0;
    int cs_cnt = 0, rst_age = 0;
    logic cs_prev = 1'b1;
    logic armed_ok = 1'b0;
    logic prev_rxv = 1'b0;
    logic [7:0] exp_rx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every received byte must match the master's queue, 4 cycles after the last sample edge.
    always @(negedge clk) begin
        if (cs_n == cs_prev) cs_cnt++;
        else cs_cnt = 0;
        cs_prev = cs_n;
        if (rst) begin
            armed_ok = 1'b0;
            rst_age  = 0;
            prev_rxv = 1'b0;
        end else begin
            rst_age++;
            if (cs_n && cs_cnt >= 4 && rst_age >= 4) armed_ok = 1'b1;
            if (!miso_oe) chk("miso_gated", miso, 1'b0);
            if (cs_cnt >= 5 && rst_age >= 6) begin
                chk("miso_oe", miso_oe, !cs_n && armed_ok);
                chk("busy", busy, !cs_n && armed_ok);
            end
            if (rx_valid) begin
                n_rxv++;
                chk("rx_valid_width", prev_rxv, 1'b0);
                chk("rx_expected", exp_rx_q.size() > 0, 1'b1);
                if (exp_rx_q.size() > 0) begin
                    chk("rx_data", rx_data, exp_rx_q[0]);
                    void'(exp_rx_q.pop_front());
                end
                chk("rx_latency", cyc - last_samp_cyc, 4);
            end
            if (tx_underrun) n_ur++;
            if (frame_err) n_fe++;
            prev_rxv = rx_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_tx(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        tx_valid = 1'b1;
        tx_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (tx_ready) ok = 1'b1;
            tick(1);
        end
        tx_valid = 1'b0;
        chk("tx_accept", ok, 1'b1);
    endtask

    task automatic begin_frame(input logic [1:0] m);
        mode = m;
        sck  = m[1];
        tick(2);
        cs_n = 1'b0;
        tick(10);
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        tick(10);
    endtask

    task automatic xfer(input logic [1:0] m, input logic [7:0] dout, input int nbits,
                        output logic [7:0] din);
        din = 8'h00;
        if (nbits == 8) exp_rx_q.push_back(dout);
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!m[0]) begin
                mosi = dout[i];
                tick(H);
                sck = ~m[1];
                din[i] = miso;
                last_samp_cyc = cyc;
                tick(H);
                sck = m[1];
            end else begin
                tick(H);
                sck  = ~m[1];
                mosi = dout[i];
                tick(H);
                sck = m[1];
                din[i] = miso;
                last_samp_cyc = cyc;
            end
        end
        tick(H);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"}, miso, 1'b0);
        chk({tag, "_miso_oe"}, miso_oe, 1'b0);
        chk({tag, "_rx_data"}, rx_data, 8'h00);
        chk({tag, "_rx_valid"}, rx_valid, 1'b0);
        chk({tag, "_tx_ready"}, tx_ready, 1'b1);
        chk({tag, "_tx_underrun"}, tx_underrun, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] d1, d2;
        int ur0, fe0, rv0;
        logic ok;
        rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; mode = 2'b00;
        tx_data = 8'h00; tx_valid = 1'b0;
        tick(4);
        chk_reset_vals("reset");
        rst = 1'b0;
        tick(10);

        // Mode 0, preloaded 0xA5, master sends 0x91
        ur0 = n_ur; rv0 = n_rxv;
        load_tx(8'hA5);
        begin_frame(2'b00);
        chk("t1_oe_selected", miso_oe, 1'b1);
        xfer(2'b00, 8'h91, 8, d1);
        end_frame();
        chk("t1_miso_byte", d1, 8'hA5);
        chk("t1_rx_data", rx_data, 8'h91);
        chk("t1_rx_count", n_rxv - rv0, 1);
        chk("t1_underrun", n_ur - ur0, 0);

        // Modes 1..3, 0x3C out / 0xC3 back; mode pin wiggled mid-frame must be ignored
        for (int m = 1; m < 4; m++) begin
            logic [1:0] mm;
            mm = 2'(m);
            ur0 = n_ur;
            load_tx(8'hC3);
            begin_frame(mm);
            mode = ~mm;
            chk("t2_oe_selected", miso_oe, 1'b1);
            xfer(mm, 8'h3C, 8, d1);
            mode = mm;
            end_frame();
            chk("t2_miso_byte", d1, 8'hC3);
            chk("t2_rx_data", rx_data, 8'h3C);
            chk("t2_oe_released", miso_oe, 1'b0);
            chk("t2_underrun", n_ur - ur0, 0);
        end

        // Two bytes under one CS with only 0x55 loaded
        ur0 = n_ur; rv0 = n_rxv;
        load_tx(8'h55);
        begin_frame(2'b00);
        xfer(2'b00, 8'h12, 8, d1);
        xfer(2'b00, 8'h34, 8, d2);
        end_frame();
        chk("t3_miso_b0", d1, 8'h55);
        chk("t3_miso_b1", d2, 8'h00);
        chk("t3_rx_count", n_rxv - rv0, 2);
        chk("t3_underrun", n_ur - ur0, 1);
        chk("t3_rx_data", rx_data, 8'h34);

        // CS raised after 5 bits; holding byte loaded mid-frame must survive
        ur0 = n_ur; rv0 = n_rxv; fe0 = n_fe;
        load_tx(8'h66);
        begin_frame(2'b00);
        load_tx(8'h99);
        xfer(2'b00, 8'hAB, 5, d1);
        end_frame();
        chk("t4_frame_err", n_fe - fe0, 1);
        chk("t4_no_rx", n_rxv - rv0, 0);
        chk("t4_rx_data_kept", rx_data, 8'h34);
        chk("t4_partial_miso", d1, 8'h60);
        chk("t4_hold_kept", tx_ready, 1'b0);
        begin_frame(2'b00);
        xfer(2'b00, 8'h7E, 8, d1);
        end_frame();
        chk("t4_rx_data", rx_data, 8'h7E);
        chk("t4_miso_byte", d1, 8'h99);
        chk("t4_underrun", n_ur - ur0, 0);

        // tx_valid held with 0x01 then 0x02
        ur0 = n_ur;
        mode = 2'b00; sck = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h01;
        chk("t5_ready_first", tx_ready, 1'b1);
        tick(1);
        tx_data = 8'h02;
        chk("t5_ready_full", tx_ready, 1'b0);
        tick(1);
        chk("t5_ready_still_full", tx_ready, 1'b0);
        cs_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (tx_ready) ok = 1'b1;
            tick(1);
        end
        tx_valid = 1'b0;
        chk("t5_accept_after_arm", ok, 1'b1);
        chk("t5_ready_after", tx_ready, 1'b0);
        chk("t5_busy", busy, 1'b1);
        tick(10);
        xfer(2'b00, 8'hAA, 8, d1);
        xfer(2'b00, 8'hBB, 8, d2);
        end_frame();
        chk("t5_miso_b0", d1, 8'h01);
        chk("t5_miso_b1", d2, 8'h02);
        chk("t5_underrun", n_ur - ur0, 0);

        // Reset mid-frame with CS low
        fe0 = n_fe; rv0 = n_rxv;
        load_tx(8'h5A);
        begin_frame(2'b00);
        xfer(2'b00, 8'hFF, 3, d1);
        rst = 1'b1;
        tick(2);
        chk_reset_vals("t6_rst");
        rst = 1'b0;
        tick(12);
        chk("t6_not_armed_busy", busy, 1'b0);
        chk("t6_not_armed_oe", miso_oe, 1'b0);
        chk("t6_rx_data", rx_data, 8'h00);
        end_frame();
        load_tx(8'h0F);
        begin_frame(2'b00);
        xfer(2'b00, 8'hF0, 8, d1);
        end_frame();
        chk("t6_rx_after", rx_data, 8'hF0);
        chk("t6_miso_byte", d1, 8'h0F);
        chk("t6_frame_err", n_fe - fe0, 0);
        chk("t6_rx_count", n_rxv - rv0, 1);

        chk("rx_queue_drained", exp_rx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI slave endpoint that sits directly downstream of the `spi` master peripheral, attached to one of its `spi_cs` lines and to `spi_sck`/`spi_mosi`/`spi_miso`. It oversamples the SPI pins in the system clock domain and supports all four CPOL/CPHA modes, MSB first, 8-bit frames. It presents each received byte as a one-cycle `rx_valid` pulse and takes transmit bytes through a valid/ready holding register. It is both the on-chip slave for loopback builds and the reference slave used by the `spi` bench.

## Interface
- No parameters; frame width fixed at 8 bits.
- `clk` in 1: system clock; all logic rising-edge.
- `rst` in 1: synchronous reset, active-high.
- `spi_sck` in 1: SPI clock from master (asynchronous to `clk`).
- `spi_cs_n` in 1: chip select, active-low (one bit of master `spi_cs`).
- `spi_mosi` in 1: master-out data.
- `spi_miso` out 1: slave-out data.
- `spi_miso_oe` out 1: MISO output enable; high while selected.
- `mode` in 2: {CPOL, CPHA}, latched at CS assertion.
- `tx_data` in 8: next byte to send.
- `tx_valid` in 1: `tx_data` offered.
- `tx_ready` out 1: holding register empty; transfer when `tx_valid & tx_ready`.
- `rx_data` out 8: last received byte; held until the next byte completes.
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated.
- `tx_underrun` out 1: one-cycle pulse, byte boundary reached with holding register empty.
- `frame_err` out 1: one-cycle pulse, CS deasserted with a partial byte.
- `busy` out 1: state is ARM or SHIFT.

## Operation
- Input sync: `spi_sck`, `spi_cs_n`, `spi_mosi` each pass through 2 flops. `spi_sck` gets a third flop for edge detection. Sync flops reset to sck=0, cs_n=1, mosi=0.
- Leading edge: synced SCK leaves the CPOL idle level. Trailing edge: SCK returns to it. Edges are acted on only in SHIFT.
- CPHA=0: sample MOSI on the leading edge, shift MISO on the trailing edge. MSB is on MISO from ARM onward.
- CPHA=1: shift MISO on the leading edge, except the first leading edge of a byte, which presents the MSB. Sample on the trailing edge.
- States:
  - IDLE: waits for synced cs_n=0, then goes to ARM.
  - ARM, one cycle:
    - Latch `mode`.
    - Load the shift register from the holding register (holding becomes empty) or, if empty, load 0x00 and pulse `tx_underrun`.
    - Bit count = 0; go to SHIFT.
  - SHIFT, each sample edge:
    - rx shift in MSB first; count+1.
    - At count 7→0 (wrap): `rx_data` ← assembled byte, `rx_valid` pulse next cycle.
    - The tx shift register reloads from holding (or 0x00 + `tx_underrun`), so back-to-back bytes need no CS toggle.
  - Synced cs_n=1 in SHIFT goes to IDLE. If count≠0, pulse `frame_err` and discard the partial byte with no `rx_valid`. An unconsumed holding byte is kept.
  - WAIT_HI: entered from reset. Leaves for IDLE only once synced cs_n=1, so no frame is armed mid-transfer.
- `tx_ready` = holding empty. A write and a byte-boundary consumption in the same cycle: the boundary sees the register contents at cycle start. If empty, it sends 0x00 and flags underrun, and the write fills holding for the next byte.
- `mode` changes while `busy` are ignored.
- `spi_miso_oe` = synced cs_n low and state≠WAIT_HI. `spi_miso` = tx shift MSB, 0 when not enabled.

## Timing
- Reset values:
  - `spi_miso` 0, `spi_miso_oe` 0
  - `rx_data` 0x00, `rx_valid` 0
  - `tx_ready` 1
  - `tx_underrun` 0, `frame_err` 0
  - `busy` 0
  - state WAIT_HI
- Pin edge → internal action: 3 `clk` cycles (2 sync + detect). `rx_valid` asserts 4 cycles after the final sampling pin edge.
- MISO updates 3 cycles after the pin shift edge.
- Required master timing: each SCK half-period ≥ 4 `clk` cycles; CS-fall to first SCK edge ≥ 5 cycles; last SCK edge to CS-rise ≥ 4 cycles. Slower SCK is unrestricted.
- `tx_ready` drops the cycle after an accepted write and rises the cycle after ARM or a byte-boundary consumption.

## Test plan
- Mode 0, `tx_data`=0xA5 preloaded, master sends 0x91 → `rx_data`=0x91 with one `rx_valid` pulse; MISO bits sample as 0xA5; no `tx_underrun`.
- Modes 1, 2, 3, each with master 0x3C and slave 0xC3 → both sides receive the other's byte correctly; `spi_miso_oe` high only while CS low.
- Two bytes under one CS (0x12, 0x34), slave with only 0x55 loaded → `rx_valid` twice (0x12, 0x34); slave sends 0x55 then 0x00; `tx_underrun` pulses once at the second boundary.
- CS raised after 5 bits → `frame_err` pulse, no `rx_valid`, `rx_data` keeps its old value; the next full frame of 0x7E receives correctly.
- `tx_valid` held high with 0x01, 0x02 on consecutive cycles → only 0x01 accepted (`tx_ready` 0); 0x02 accepted after ARM.
- `rst` pulsed mid-frame with CS low → outputs return to reset values; nothing armed until CS goes high then low; the following frame 0xF0 receives correctly.
